md_sequencer: RTL and testbench

Multiply/divide sequencer for the pipelined MIPS core with exceptions. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, owns the HI/LO registers, and models fixed multi-cycle latency with a busy counter. It exposes `busy` so the hazard unit can stall MFHI/MFLO and further MD instructions. It also honours the exception-flush `cancel` so a flushed instruction never modifies HI/LO.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_arith.sv | 82 ++++++++
 rtl/md_sequencer.sv | 114 +++++++++++
 tb/tb_md_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the multiply/divide sequencer.
//   md_op_t     - MD operation encodings presented on md_sequencer.op
//   md_state_t  - sequencer FSM states
//   md_cnt_width() / MD_CNT_W - busy-counter width derived from the max latency
// Build option: MD_DIV_ZERO_HOLD_EN (used by md_arith) selects the
// division-by-zero behaviour.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Counter must hold the larger of the two latencies.
    function automatic int unsigned md_cnt_width(input int unsigned mult_cycles,
                                                 input int unsigned div_cycles);
        int unsigned max_lat;
        max_lat = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_lat) + 1;
    endfunction

    localparam int unsigned MD_CNT_W = md_cnt_width(5, 10);

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
// Ports:
//   op       in   md_op_t  operation (only MULT/MULTU/DIV/DIVU produce results)
//   src_a    in   32       multiplicand / dividend
//   src_b    in   32       multiplier / divisor
//   hi       out  32       product[63:32] or remainder
//   lo       out  32       product[31:0]  or quotient
//   write_en out  1        result may be committed to HI/LO
// Build option MD_DIV_ZERO_HOLD_EN: when defined, a zero divisor clears
// write_en so HI/LO keep their old values; otherwise LO = all ones, HI = src_a.
import md_pkg::*;

module md_arith (
    input  md_op_t      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        write_en
);

    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;

    // Signed division works on magnitudes and fixes signs afterwards, which
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow traps.
    always_comb begin
        hi       = '0;
        lo       = '0;
        write_en = 1'b1;
        prod     = '0;
        mag_a    = src_a;
        mag_b    = src_b;
        quot     = '0;
        rem      = '0;
        neg_q    = 1'b0;
        neg_r    = 1'b0;
        case (op)
            MD_MULT: begin
                prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
                hi   = prod[63:32];
                lo   = prod[31:0];
            end
            MD_MULTU: begin
                prod = {32'd0, src_a} * {32'd0, src_b};
                hi   = prod[63:32];
                lo   = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (op == MD_DIV) begin
                    mag_a = src_a[31] ? (~src_a + 32'd1) : src_a;
                    mag_b = src_b[31] ? (~src_b + 32'd1) : src_b;
                    neg_q = src_a[31] ^ src_b[31];
                    neg_r = src_a[31];
                end
                if (src_b == '0) begin
`ifdef MD_DIV_ZERO_HOLD_EN
                    write_en = 1'b0;
`else
                    lo = '1;
                    hi = src_a;
`endif
                end else begin
                    quot = mag_a / mag_b;
                    rem  = mag_a % mag_b;
                    lo   = neg_q ? (~quot + 32'd1) : quot;
                    hi   = neg_r ? (~rem + 32'd1) : rem;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MULT/DIV sequencer owning the HI/LO registers.
// Parameters: MULT_CYCLES (default 5), DIV_CYCLES (default 10), both >= 1.
// Ports:
//   clk      in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset
//   op_valid in   1   MD instruction present in E
//   op       in   3   md_op_t encoding
//   src_a    in   32  rs value
//   src_b    in   32  rt value
//   cancel   in   1   flush of the E-stage instruction this cycle
//   busy     out  1   MULT/DIV in flight (registered)
//   done     out  1   one-cycle pulse when HI/LO take a MULT/DIV result
//   hi       out  32  HI register
//   lo       out  32  LO register
// Build option MD_DIV_ZERO_HOLD_EN: see md_arith (division-by-zero rule).
import md_pkg::*;

module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]     hi_pend;
    logic [31:0]     lo_pend;
    logic            we_pend;

    md_op_t          op_e;
    logic            accept;
    logic [31:0]     ar_hi;
    logic [31:0]     ar_lo;
    logic            ar_we;

    assign op_e   = md_op_t'(op);
    assign accept = op_valid & ~cancel & (state == ST_IDLE);

    md_arith u_arith (
        .op       (op_e),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi       (ar_hi),
        .lo       (ar_lo),
        .write_en (ar_we)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
            we_pend <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_e)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                cnt     <= ((op_e == MD_MULT) || (op_e == MD_MULTU))
                                           ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                                hi_pend <= ar_hi;
                                lo_pend <= ar_lo;
                                we_pend <= ar_we;
                                busy    <= 1'b1;
                                state   <= ST_BUSY;
                            end
                            MD_MTHI: hi <= src_a;
                            MD_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Commit on the last busy cycle so HI/LO and done appear
                    // together in the first cycle busy is low again.
                    if (cnt == CNT_W'(1)) begin
                        if (we_pend) begin
                            hi <= hi_pend;
                            lo <= lo_pend;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed self-checking bench for md_sequencer.
// Build option MD_DIV_ZERO_HOLD_EN selects the expected division-by-zero result.
import md_pkg::*;

module tb_md_sequencer;

    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks;
    int unsigned n_fail;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one cycle; returns in the cycle after acceptance.
    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic canc);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        cancel   = canc;
        step();
        op_valid = 1'b0;
        op       = MD_NONE;
        cancel   = 1'b0;
    endtask

    // Counts remaining busy cycles (bounded), then checks count and done pulse.
    task automatic wait_done(input string tag, input int unsigned n_exp);
        int unsigned nb;
        nb = 0;
        for (int g = 0; g < 40 && busy; g++) begin
            nb++;
            step();
        end
        check({tag, "_busy_cycles"}, nb, n_exp);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        op_valid = 1'b0;
        op       = MD_NONE;
        src_a    = '0;
        src_b    = '0;
        cancel   = 1'b0;
        step();
        step();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        step();

        // MULT -3 * 5
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
        wait_done("mult", 5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);
        step();
        check("mult_done_low", {31'd0, done}, 32'd0);

        // DIVU 100 / 7
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        wait_done("divu", 10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // DIV -7 / 2
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_done("div_neg", 10);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        // DIV 7 / -2 -> q = -3, r = 1
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
        wait_done("div_negb", 10);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'd1);

        // DIV overflow case
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done("div_ovf", 10);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h0);

        // DIVU large unsigned
        issue(MD_DIVU, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_done("divu_big", 10);
        check("divu_big_lo", lo, 32'h7FFFFFFF);
        check("divu_big_hi", hi, 32'd1);

        // MTHI / MTLO: immediate, no busy
        issue(MD_MTHI, 32'h12345678, 32'h0, 1'b0);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo_kept", lo, 32'h7FFFFFFF);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);
        issue(MD_MTLO, 32'hCAFEF00D, 32'h0, 1'b0);
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", hi, 32'h12345678);

        // MULTU max * max
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done("multu", 5);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        // Cancelled DIV: nothing accepted
        issue(MD_DIV, 32'd50, 32'd3, 1'b1);
        check("cancel_busy0", {31'd0, busy}, 32'd0);
        step();
        check("cancel_busy1", {31'd0, busy}, 32'd0);
        check("cancel_hi", hi, 32'hFFFFFFFE);
        check("cancel_lo", lo, 32'h00000001);

        // cancel during an in-flight MULT does not stop it
        issue(MD_MULT, 32'd7, 32'd6, 1'b0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        wait_done("mult_cancel_inflight", 4);
        check("mult_ci_lo", lo, 32'd42);
        check("mult_ci_hi", hi, 32'd0);

        // Division by zero
        issue(MD_DIV, 32'd9, 32'd0, 1'b0);
        wait_done("div0", 10);
`ifdef MD_DIV_ZERO_HOLD_EN
        check("div0_lo", lo, 32'd42);
        check("div0_hi", hi, 32'd0);
`else
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'd9);
`endif
        issue(MD_DIVU, 32'hFFFFFFF0, 32'd0, 1'b0);
        wait_done("divu0", 10);
`ifdef MD_DIV_ZERO_HOLD_EN
        check("divu0_lo", lo, 32'd42);
        check("divu0_hi", hi, 32'd0);
`else
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'hFFFFFFF0);
`endif

        // Asynchronous reset in the 3rd busy cycle of a DIV
        issue(MD_DIV, 32'd100, 32'd3, 1'b0);
        step();
        step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        reset_n = 1'b1;
        step();

        // MULT 2*3 with an op presented while busy (must be ignored)
        issue(MD_MULT, 32'd2, 32'd3, 1'b0);
        op_valid = 1'b1;
        op       = MD_DIVU;
        src_a    = 32'd1000;
        src_b    = 32'd10;
        step();
        op_valid = 1'b0;
        op       = MD_NONE;
        wait_done("mult_after_rst", 4);
        check("mult_ar_lo", lo, 32'd6);
        check("mult_ar_hi", hi, 32'd0);
        step();
        check("ignored_op_busy", {31'd0, busy}, 32'd0);
        check("ignored_op_lo", lo, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
